snake_body_streamer: RTL and testbench



---
 rtl/snake_body_streamer.sv | 175 +++++++++++++++++
 tb/tb_snake_body_streamer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_streamer.sv
// rtl/snake_body_streamer.sv - snake body state and head-to-tail segment streamer
// Optional SNAKE_WRAP_EN: wrap at playfield edges instead of flagging a wall hit.
module snake_body_streamer #(
  parameter int GAME_WIDTH  = 18,
  parameter int GAME_HEIGHT = 13,
  parameter int MAX_LEN     = 64,
  parameter int INIT_LEN    = 3,
  parameter int START_X     = 4,
  parameter int START_Y     = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           scan_start,
  input  logic                           step_valid,
  output logic                           step_ready,
  input  logic [1:0]                     step_dir,
  input  logic                           step_grow,
  output logic [4:0]                     snake_x,
  output logic [3:0]                     snake_y,
  output logic [1:0]                     snake_dir,
  output logic                           snake_first,
  output logic                           snake_last,
  output logic                           snake_valid,
  output logic [4:0]                     snake_head_x,
  output logic [3:0]                     snake_head_y,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           full,
  output logic                           wall_hit,
  output logic                           collided
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;

  logic [1:0]    ring [MAX_LEN];
  logic [PW-1:0] head_ptr, rd_ptr, ptr_dec;
  logic [4:0]    walk_x;
  logic [3:0]    walk_y;
  logic [LW-1:0] beat_idx;
  logic          step_fire, step_oob, stream_beat;
  logic [8:0]    step_pos;

  function automatic logic [8:0] move_pos(input logic [4:0] x, input logic [3:0] y,
                                          input logic [1:0] d);
    logic [4:0] nx;
    logic [3:0] ny;
    nx = x;
    ny = y;
    case (d)
      2'd0: ny = y - 4'd1;
      2'd1: ny = y + 4'd1;
      2'd2: nx = x - 5'd1;
      default: nx = x + 5'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    if (d == 2'd0 && y == 4'd1) ny = 4'(GAME_HEIGHT);
    if (d == 2'd1 && y == 4'(GAME_HEIGHT)) ny = 4'd1;
    if (d == 2'd2 && x == 5'd1) nx = 5'(GAME_WIDTH);
    if (d == 2'd3 && x == 5'(GAME_WIDTH)) nx = 5'd1;
`endif
    return {nx, ny};
  endfunction

  assign step_ready  = (state_q == IDLE) && !scan_start;
  assign step_fire   = step_valid && step_ready;
  assign full        = (length == LW'(MAX_LEN));
  assign ptr_dec     = head_ptr - PW'(1);
  assign step_pos    = move_pos(snake_head_x, snake_head_y, step_dir);
  assign stream_beat = (state_q == STREAM) && (beat_idx != length);

`ifdef SNAKE_WRAP_EN
  assign step_oob = 1'b0;
  assign wall_hit = 1'b0;
`else
  logic [5:0] tx;
  logic [4:0] ty;
  logic       wall_q;

  always_comb begin
    tx = {1'b0, snake_head_x};
    ty = {1'b0, snake_head_y};
    case (step_dir)
      2'd0: ty = ty - 5'd1;
      2'd1: ty = ty + 5'd1;
      2'd2: tx = tx - 6'd1;
      default: tx = tx + 6'd1;
    endcase
  end

  assign step_oob = (tx == 6'd0) || (tx > 6'(GAME_WIDTH)) ||
                    (ty == 5'd0) || (ty > 5'(GAME_HEIGHT));
  assign wall_hit = wall_q;

  always_ff @(posedge clk) begin
    if (rst) wall_q <= 1'b0;
    else if (step_fire && step_oob) wall_q <= 1'b1;
  end
`endif

  always_comb begin
    state_d = state_q;
    if (scan_start) state_d = STREAM;
    else if (state_q == STREAM && beat_idx == length) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      snake_head_x <= 5'(START_X);
      snake_head_y <= 4'(START_Y);
      length       <= LW'(INIT_LEN);
      head_ptr     <= '0;
      rd_ptr       <= '0;
      walk_x       <= '0;
      walk_y       <= '0;
      beat_idx     <= '0;
      snake_x      <= '0;
      snake_y      <= '0;
      snake_dir    <= '0;
      snake_first  <= 1'b0;
      snake_last   <= 1'b0;
      snake_valid  <= 1'b0;
      collided     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) ring[i] <= 2'd2;
    end else begin
      state_q <= state_d;

      // Out-of-field steps are consumed without touching the body.
      if (step_fire && !step_oob) begin
        {snake_head_x, snake_head_y} <= step_pos;
        head_ptr      <= ptr_dec;
        ring[ptr_dec] <= {step_dir[1], ~step_dir[0]};
        if (step_grow && !full) length <= length + LW'(1);
      end

      if (scan_start) begin
        snake_x          <= snake_head_x;
        snake_y          <= snake_head_y;
        snake_dir        <= ring[head_ptr];
        snake_first      <= 1'b1;
        snake_last       <= (length == LW'(1));
        snake_valid      <= 1'b1;
        {walk_x, walk_y} <= move_pos(snake_head_x, snake_head_y, ring[head_ptr]);
        rd_ptr           <= head_ptr + PW'(1);
        beat_idx         <= LW'(1);
      end else if (stream_beat) begin
        snake_x          <= walk_x;
        snake_y          <= walk_y;
        snake_dir        <= ring[rd_ptr];
        snake_first      <= 1'b0;
        snake_last       <= (beat_idx == length - LW'(1));
        snake_valid      <= 1'b1;
        {walk_x, walk_y} <= move_pos(walk_x, walk_y, ring[rd_ptr]);
        rd_ptr           <= rd_ptr + PW'(1);
        beat_idx         <= beat_idx + LW'(1);
      end else begin
        snake_x     <= '0;
        snake_y     <= '0;
        snake_dir   <= '0;
        snake_first <= 1'b0;
        snake_last  <= 1'b0;
        snake_valid <= 1'b0;
      end

      // Head cannot move while streaming, so the live head is the reference.
      if (snake_valid && !snake_first &&
          snake_x == snake_head_x && snake_y == snake_head_y)
        collided <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snake_body_streamer.sv
// tb/tb_snake_body_streamer.sv - self-checking bench for snake_body_streamer
module tb_snake_body_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_start = 1'b0;
  logic       step_valid = 1'b0;
  logic       step_ready;
  logic [1:0] step_dir = 2'd0;
  logic       step_grow = 1'b0;
  logic [4:0] snake_x;
  logic [3:0] snake_y;
  logic [1:0] snake_dir;
  logic       snake_first, snake_last, snake_valid;
  logic [4:0] snake_head_x;
  logic [3:0] snake_head_y;
  logic [6:0] length;
  logic       full, wall_hit, collided;

  snake_body_streamer dut (
    .clk(clk), .rst(rst), .scan_start(scan_start),
    .step_valid(step_valid), .step_ready(step_ready), .step_dir(step_dir),
    .step_grow(step_grow), .snake_x(snake_x), .snake_y(snake_y),
    .snake_dir(snake_dir), .snake_first(snake_first), .snake_last(snake_last),
    .snake_valid(snake_valid), .snake_head_x(snake_head_x),
    .snake_head_y(snake_head_y), .length(length), .full(full),
    .wall_hit(wall_hit), .collided(collided)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         mhx, mhy, mlen;
  logic [1:0] mdirs[$];
  logic [12:0] exp_q[$];

  typedef struct {
    int         op;      // 0 reset, 1 step, 2 scan
    logic [1:0] dir;
    logic       grow;
    int         ehx, ehy, elen;
    logic       ewall, ecoll;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] opp(input logic [1:0] d);
    case (d)
      2'd0: return 2'd1;
      2'd1: return 2'd0;
      2'd2: return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  task automatic move(inout int x, inout int y, input logic [1:0] d, output bit oob);
    case (d)
      2'd0: y = y - 1;
      2'd1: y = y + 1;
      2'd2: x = x - 1;
      default: x = x + 1;
    endcase
    oob = (x < 1 || x > 18 || y < 1 || y > 13);
`ifdef SNAKE_WRAP_EN
    if (x < 1) x = 18;
    if (x > 18) x = 1;
    if (y < 1) y = 13;
    if (y > 13) y = 1;
    oob = 1'b0;
`endif
  endtask

  task automatic model_reset();
    mhx = 4; mhy = 7; mlen = 3;
    mdirs.delete();
    for (int i = 0; i < 64; i++) mdirs.push_back(2'd2);
  endtask

  task automatic model_step(input logic [1:0] d, input logic g);
    int nx, ny;
    bit oob;
    nx = mhx; ny = mhy;
    move(nx, ny, d, oob);
    if (!oob) begin
      mhx = nx; mhy = ny;
      mdirs.push_front(opp(d));
      void'(mdirs.pop_back());
      if (g && mlen < 64) mlen++;
    end
  endtask

  task automatic build_expected();
    int x, y;
    bit oob;
    exp_q.delete();
    x = mhx; y = mhy;
    for (int k = 0; k < mlen; k++) begin
      exp_q.push_back({5'(x), 4'(y), mdirs[k], k == 0, k == mlen - 1});
      move(x, y, mdirs[k], oob);
    end
  endtask

  function automatic logic [12:0] beat();
    return {snake_x, snake_y, snake_dir, snake_first, snake_last};
  endfunction

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
  endtask

  task automatic do_step(input logic [1:0] d, input logic g);
    @(negedge clk);
    step_valid = 1'b1; step_dir = d; step_grow = g;
    #1;
    for (int c = 0; c < 200 && !step_ready; c++) begin
      @(negedge clk);
      #1;
    end
    if (!step_ready) check("step_ready_timeout", 32'(step_ready), 32'd1);
    @(negedge clk) step_valid = 1'b0;
    model_step(d, g);
  endtask

  // Pushes the model's expected beats, then pops one per DUT beat.
  task automatic do_scan();
    build_expected();
    @(negedge clk) scan_start = 1'b1;
    @(negedge clk) scan_start = 1'b0;
    while (exp_q.size() > 0) begin
      check("beat_valid", 32'(snake_valid), 32'd1);
      check("beat_ready_low", 32'(step_ready), 32'd0);
      check("beat", 32'(beat()), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    check("end_valid", 32'(snake_valid), 32'd0);
    check("end_ready", 32'(step_ready), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{0, 2'd0, 1'b0, 4, 7, 3, 1'b0, 1'b0};
    tbl[1]  = '{2, 2'd0, 1'b0, 4, 7, 3, 1'b0, 1'b0};
    tbl[2]  = '{1, 2'd0, 1'b0, 4, 6, 3, 1'b0, 1'b0};
    tbl[3]  = '{2, 2'd0, 1'b0, 4, 6, 3, 1'b0, 1'b0};
    tbl[4]  = '{0, 2'd0, 1'b0, 4, 7, 3, 1'b0, 1'b0};
    tbl[5]  = '{1, 2'd3, 1'b1, 5, 7, 4, 1'b0, 1'b0};
    tbl[6]  = '{2, 2'd0, 1'b0, 5, 7, 4, 1'b0, 1'b0};
    tbl[7]  = '{0, 2'd0, 1'b0, 4, 7, 3, 1'b0, 1'b0};
    tbl[8]  = '{1, 2'd2, 1'b0, 3, 7, 3, 1'b0, 1'b0};
    tbl[9]  = '{1, 2'd2, 1'b0, 2, 7, 3, 1'b0, 1'b0};
    tbl[10] = '{1, 2'd2, 1'b0, 1, 7, 3, 1'b0, 1'b0};
`ifdef SNAKE_WRAP_EN
    tbl[11] = '{1, 2'd2, 1'b0, 18, 7, 3, 1'b0, 1'b0};
    tbl[12] = '{2, 2'd0, 1'b0, 18, 7, 3, 1'b0, 1'b0};
`else
    tbl[11] = '{1, 2'd2, 1'b0, 1, 7, 3, 1'b1, 1'b0};
    tbl[12] = '{2, 2'd0, 1'b0, 1, 7, 3, 1'b1, 1'b0};
`endif
    tbl[13] = '{0, 2'd0, 1'b0, 4, 7, 3, 1'b0, 1'b0};
    tbl[14] = '{1, 2'd3, 1'b1, 5, 7, 4, 1'b0, 1'b0};
    tbl[15] = '{1, 2'd3, 1'b1, 6, 7, 5, 1'b0, 1'b0};
    tbl[16] = '{1, 2'd0, 1'b0, 6, 6, 5, 1'b0, 1'b0};
    tbl[17] = '{1, 2'd2, 1'b0, 5, 6, 5, 1'b0, 1'b0};
    tbl[18] = '{1, 2'd1, 1'b0, 5, 7, 5, 1'b0, 1'b0};
    tbl[19] = '{2, 2'd0, 1'b0, 5, 7, 5, 1'b0, 1'b1};

    model_reset();
    repeat (2) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      case (tbl[i].op)
        0: begin
          do_reset();
          check("rst_valid", 32'(snake_valid), 32'd0);
          check("rst_ready", 32'(step_ready), 32'd1);
        end
        1: do_step(tbl[i].dir, tbl[i].grow);
        default: do_scan();
      endcase
      check($sformatf("v%0d_head_x", i), 32'(snake_head_x), 32'(tbl[i].ehx));
      check($sformatf("v%0d_head_y", i), 32'(snake_head_y), 32'(tbl[i].ehy));
      check($sformatf("v%0d_len", i), 32'(length), 32'(tbl[i].elen));
      check($sformatf("v%0d_wall", i), 32'(wall_hit), 32'(tbl[i].ewall));
      check($sformatf("v%0d_coll", i), 32'(collided), 32'(tbl[i].ecoll));
    end

    // Command held across a pass waits for the IDLE cycle after the last beat.
    do_reset();
    @(negedge clk);
    scan_start = 1'b1; step_valid = 1'b1; step_dir = 2'd0; step_grow = 1'b0;
    #1 check("hs_scan_priority", 32'(step_ready), 32'd0);
    @(negedge clk) scan_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("hs_beat_valid", 32'(snake_valid), 32'd1);
      check("hs_busy", 32'(step_ready), 32'd0);
      @(negedge clk);
    end
    check("hs_idle_valid", 32'(snake_valid), 32'd0);
    check("hs_idle_ready", 32'(step_ready), 32'd1);
    @(negedge clk) step_valid = 1'b0;
    model_step(2'd0, 1'b0);
    check("hs_head_y", 32'(snake_head_y), 32'd6);

    // Restart on beat 1 returns to the head.
    build_expected();
    @(negedge clk) scan_start = 1'b1;
    @(negedge clk) scan_start = 1'b0;
    check("rs_beat0", 32'(beat()), 32'(exp_q[0]));
    @(negedge clk);
    check("rs_beat1", 32'(beat()), 32'(exp_q[1]));
    scan_start = 1'b1;
    @(negedge clk) scan_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rs_valid", 32'(snake_valid), 32'd1);
      check("rs_beat", 32'(beat()), 32'(exp_q[k]));
      @(negedge clk);
    end
    check("rs_end_valid", 32'(snake_valid), 32'd0);

    // Reset during a pass drops valid on the next cycle.
    @(negedge clk) scan_start = 1'b1;
    @(negedge clk) scan_start = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
    check("rst_mid_valid", 32'(snake_valid), 32'd0);
    check("rst_mid_len", 32'(length), 32'd3);

    // Serpentine fill to MAX_LEN, then one grow while full.
    for (int k = 0; k < 62; k++) begin
      logic [1:0] d;
      if (k < 14) d = 2'd3;
      else if (k < 20) d = 2'd1;
      else if (k < 37) d = 2'd2;
      else if (k < 49) d = 2'd0;
      else d = 2'd3;
      do_step(d, 1'b1);
      if (k == 60) begin
        check("fill_len", 32'(length), 32'd64);
        check("fill_full", 32'(full), 32'd1);
      end
    end
    check("full_grow_len", 32'(length), 32'd64);
    check("full_head_x", 32'(snake_head_x), 32'd14);
    check("full_head_y", 32'(snake_head_y), 32'd1);
    do_scan();
    check("full_no_coll", 32'(collided), 32'd0);
    check("full_no_wall", 32'(wall_hit), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
